// File: rtl/wasm_instr_loader.sv
// rtl/wasm_instr_loader.sv - wasm byte-stream loader: preamble check, window packing, memory write port
module wasm_instr_loader #(
    parameter int WIN     = 4,
    parameter int LOG_WIN = 2,
    parameter int CAP     = 256,
    parameter int CNT_W   = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [7:0]           s_byte,
    input  logic                 s_vld,
    input  logic                 s_last,
    output logic                 s_rdy,
    output logic                 we,
    output logic [LOG_WIN-1:0]   write_pointer_shift_minusone,
    output logic [WIN*8-1:0]     wr_data,
    output logic [CNT_W-1:0]     byte_cnt,
    output logic                 load_done,
    output logic                 hdr_err,
    output logic                 ovf_err
);

    typedef enum logic [2:0] {IDLE, HDR, BODY, DONE, ERR} state_t;

    // Preamble byte i sits at [i*8 +: 8]: 00 61 73 6d 01 00 00 00
    localparam logic [63:0] PREAMBLE = 64'h0000_0001_6d73_6100;

    state_t               state, state_nxt;
    logic [WIN*8-1:0]     pack, pack_nxt;
    logic [LOG_WIN-1:0]   lane;
    logic [CNT_W-1:0]     cnt_nxt;
    logic                 accept, start_ok, hdr_bad, cap_hit, emit;

    assign lane     = byte_cnt[LOG_WIN-1:0];
    assign cnt_nxt  = byte_cnt + 1'b1;
    assign accept   = s_vld & s_rdy;
    assign start_ok = start & ((state == IDLE) | (state == DONE) | (state == ERR));
    assign cap_hit  = (cnt_nxt == CNT_W'(CAP));
    assign hdr_bad  = accept & (state == HDR) &
                      ((s_byte != PREAMBLE[{byte_cnt[2:0], 3'b000} +: 8]) | s_last);
    // A bad header byte discards the partial window instead of emitting it
    assign emit     = accept & ~hdr_bad &
                      ((lane == LOG_WIN'(WIN - 1)) | s_last | cap_hit);

    always_comb begin
        pack_nxt = pack;
        pack_nxt[{lane, 3'b000} +: 8] = s_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_nxt = HDR;
            HDR: begin
                if (hdr_bad) begin
                    state_nxt = ERR;
                end else if (accept && cnt_nxt == CNT_W'(8)) begin
                    state_nxt = BODY;
                end
            end
            BODY: begin
                if (accept && s_last) begin
                    state_nxt = DONE;
                end else if (accept && cap_hit) begin
                    state_nxt = ERR;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_rdy = (state == HDR) | (state == BODY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we                           <= 1'b0;
            write_pointer_shift_minusone <= '0;
            wr_data                      <= '0;
            byte_cnt                     <= '0;
            pack                         <= '0;
            load_done                    <= 1'b0;
            hdr_err                      <= 1'b0;
            ovf_err                      <= 1'b0;
        end else begin
            we <= emit;
            if (start_ok) begin
                byte_cnt  <= '0;
                pack      <= '0;
                load_done <= 1'b0;
                hdr_err   <= 1'b0;
                ovf_err   <= 1'b0;
            end else if (accept) begin
                byte_cnt <= cnt_nxt;
                if (emit) begin
                    wr_data                      <= pack_nxt;
                    write_pointer_shift_minusone <= lane;
                    pack                         <= '0;
                end else if (hdr_bad) begin
                    pack <= '0;
                end else begin
                    pack <= pack_nxt;
                end
                if (hdr_bad) begin
                    hdr_err <= 1'b1;
                end
                if (state == BODY && s_last) begin
                    load_done <= 1'b1;
                end
                if (state == BODY && cap_hit && !s_last) begin
                    ovf_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wasm_instr_loader.sv
// tb/tb_wasm_instr_loader.sv - randomized self-checking bench for wasm_instr_loader
module tb_wasm_instr_loader;
    localparam int WIN = 4, LOG_WIN = 2, CAP = 16, CNT_W = 5;

    logic                 clk = 1'b0;
    logic                 rst_n, start, s_vld, s_last, s_rdy, we;
    logic [7:0]           s_byte;
    logic [LOG_WIN-1:0]   write_pointer_shift_minusone;
    logic [WIN*8-1:0]     wr_data;
    logic [CNT_W-1:0]     byte_cnt;
    logic                 load_done, hdr_err, ovf_err;

    wasm_instr_loader #(.WIN(WIN), .LOG_WIN(LOG_WIN), .CAP(CAP), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s_byte(s_byte), .s_vld(s_vld),
        .s_last(s_last), .s_rdy(s_rdy), .we(we),
        .write_pointer_shift_minusone(write_pointer_shift_minusone), .wr_data(wr_data),
        .byte_cnt(byte_cnt), .load_done(load_done), .hdr_err(hdr_err), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [LOG_WIN-1:0] sh;
        logic [WIN*8-1:0]   d;
        logic [2:0]         fl;
    } ev_t;

    ev_t        got_q[$];
    ev_t        exp_q[$];
    int         total = 0;
    int         bad = 0;
    logic [7:0] pre [8] = '{8'h00, 8'h61, 8'h73, 8'h6d, 8'h01, 8'h00, 8'h00, 8'h00};
    logic [7:0] bb[$];
    bit         blast;
    int         exp_cnt;
    logic       exp_done, exp_hdr, exp_ovf, exp_rdy;

    // Every write-strobe cycle is logged together with the flags visible in that cycle
    always @(negedge clk) begin
        if (we) got_q.push_back({write_pointer_shift_minusone, wr_data, {load_done, hdr_err, ovf_err}});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ev_t mk(int s, int len, logic [2:0] fl);
        ev_t e;
        e.d = '0;
        for (int k = 0; k < len; k++) e.d[k*8 +: 8] = bb[s+k];
        e.sh = LOG_WIN'(len - 1);
        e.fl = fl;
        return e;
    endfunction

    // Reference: which windows get written and how the load ends, from the stream alone
    task automatic model();
        int  n = bb.size();
        int  used;
        bit  hdr_fail = 0;
        exp_q.delete();
        exp_done = 0; exp_hdr = 0; exp_ovf = 0;
        for (int i = 0; i < 8 && i < n && !hdr_fail; i++) begin
            if (bb[i] !== pre[i] || (blast && i == n - 1)) begin
                hdr_fail = 1;
                exp_hdr  = 1;
                exp_cnt  = i + 1;
                exp_rdy  = 0;
                for (int w = 0; w < i / WIN; w++) exp_q.push_back(mk(w * WIN, WIN, 3'b000));
            end
        end
        if (!hdr_fail) begin
            if (blast && n <= CAP) begin
                used = n;
                exp_done = 1;
            end else begin
                used = (n < CAP) ? n : CAP;
                exp_ovf = (used == CAP);
            end
            exp_cnt = used;
            exp_rdy = !(exp_done || exp_ovf);
            for (int s = 0; s < used; s += WIN) begin
                int len = (used - s < WIN) ? used - s : WIN;
                bit fin = (s + WIN >= used);
                if (len == WIN || exp_done)
                    exp_q.push_back(mk(s, len, fin ? {exp_done, 1'b0, exp_ovf} : 3'b000));
            end
        end
    endtask

    task automatic run_load(input int gap, input string name);
        int  idx = 0;
        int  cyc = 0;
        int  n = bb.size();
        bit  acc;
        got_q.delete();
        model();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        while (idx < n && s_rdy && cyc < 400) begin
            s_vld  = ($urandom_range(99) >= gap);
            s_byte = s_vld ? bb[idx] : 8'($urandom);
            s_last = s_vld ? (blast && idx == n - 1) : 1'($urandom_range(1));
            acc    = s_vld && s_rdy;
            @(posedge clk);
            if (acc) idx++;
            cyc++;
            @(negedge clk);
        end
        s_vld = 1'b0;
        s_last = 1'b0;
        repeat (3) @(negedge clk);
        check({name, "_budget"}, cyc < 400, 1);
        check({name, "_nwe"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_we%0d_data", name, i), got_q[i].d, exp_q[i].d);
            check($sformatf("%s_we%0d_shift", name, i), got_q[i].sh, exp_q[i].sh);
            check($sformatf("%s_we%0d_flags", name, i), got_q[i].fl, exp_q[i].fl);
        end
        check({name, "_byte_cnt"}, byte_cnt, exp_cnt);
        check({name, "_load_done"}, load_done, exp_done);
        check({name, "_hdr_err"}, hdr_err, exp_hdr);
        check({name, "_ovf_err"}, ovf_err, exp_ovf);
        check({name, "_s_rdy"}, s_rdy, exp_rdy);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_s_rdy"}, s_rdy, 0);
        check({name, "_we"}, we, 0);
        check({name, "_shift"}, write_pointer_shift_minusone, 0);
        check({name, "_wr_data"}, wr_data, 0);
        check({name, "_byte_cnt"}, byte_cnt, 0);
        check({name, "_load_done"}, load_done, 0);
        check({name, "_hdr_err"}, hdr_err, 0);
        check({name, "_ovf_err"}, ovf_err, 0);
    endtask

    initial begin
        int kind, len, pos;
        rst_n = 1'b0; start = 1'b0; s_vld = 1'b0; s_last = 1'b0; s_byte = 8'h00;
        #12;
        check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        bb = '{8'h00, 8'h61, 8'h73, 8'h6d, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h07};
        blast = 1;
        run_load(0, "minimal");
        check("minimal_cnt10", byte_cnt, 10);
        check("minimal_done", load_done, 1);

        bb = '{8'h00, 8'h61, 8'h74, 8'h6d, 8'h01, 8'h00, 8'h00, 8'h00};
        blast = 0;
        run_load(0, "bad_magic");
        check("bad_magic_cnt3", byte_cnt, 3);

        bb = '{8'h00, 8'h61, 8'h73, 8'h6d, 8'h01};
        blast = 1;
        run_load(30, "short");

        bb.delete();
        for (int i = 0; i < CAP + 1; i++) bb.push_back(i < 8 ? pre[i] : 8'($urandom));
        blast = 0;
        run_load(0, "ovf");
        s_vld = 1'b1; s_byte = 8'haa; s_last = 1'b0;
        repeat (2) @(negedge clk);
        s_vld = 1'b0;
        check("ovf_byte17_cnt", byte_cnt, CAP);
        check("ovf_byte17_nwe", got_q.size(), 4);

        bb.delete();
        for (int i = 0; i < CAP; i++) bb.push_back(i < 8 ? pre[i] : 8'($urandom));
        blast = 1;
        run_load(25, "exact_fit");

        for (int t = 0; t < 24; t++) begin
            kind = $urandom_range(3);
            bb.delete();
            for (int i = 0; i < 8; i++) bb.push_back(pre[i]);
            case (kind)
                0: begin
                    len = $urandom_range(CAP - 8, 1);
                    for (int i = 0; i < len; i++) bb.push_back(8'($urandom));
                    blast = 1;
                end
                1: begin
                    pos = $urandom_range(7);
                    bb[pos] = pre[pos] ^ 8'($urandom_range(255, 1));
                    for (int i = 0; i < 4; i++) bb.push_back(8'($urandom));
                    blast = 1'($urandom_range(1));
                end
                2: begin
                    len = $urandom_range(8, 1);
                    while (bb.size() > len) void'(bb.pop_back());
                    blast = 1;
                end
                default: begin
                    len = $urandom_range(CAP + 3, CAP) - 8;
                    for (int i = 0; i < len; i++) bb.push_back(8'($urandom));
                    blast = 0;
                end
            endcase
            run_load($urandom_range(50), $sformatf("rand%0d", t));
        end

        bb.delete();
        for (int i = 0; i < 12; i++) bb.push_back(i < 8 ? pre[i] : 8'($urandom));
        blast = 0;
        run_load(0, "mid_body");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk) rst_n = 1'b1;
        got_q.delete();
        repeat (4) @(negedge clk);
        check("after_reset_nwe", got_q.size(), 0);

        bb.delete();
        for (int i = 0; i < 9; i++) bb.push_back(i < 8 ? pre[i] : 8'($urandom));
        blast = 1;
        run_load(20, "restart");
        check("restart_final_shift", got_q.size() > 0 ? got_q[got_q.size()-1].sh : 2'b11, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wasm_instr_loader.md
# wasm_instr_loader

Upstream feeder for the instruction memory controller. Accepts a raw WebAssembly binary one byte per cycle over a valid/ready stream and checks the 8-byte wasm preamble (00 61 73 6d 01 00 00 00). It packs the bytes into write windows and drives the memory's write port (`we`, `write_pointer_shift_minusone`, `wr_data`). It reports completion, a header error or an overflow error to the control FSM.

## Interface
- `WIN`, 4: write window size in bytes; must equal `write_window_size`.
- `LOG_WIN`, 2: width of the shift field, log2(WIN); must equal `log_write_window_size`.
- `CAP`, 256: maximum loadable bytes; must equal `instr_bram_depth`.
- `CNT_W`, 9: byte counter width; must satisfy 2^CNT_W > CAP.
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous reset, active-low.
- `start`  in  1  one-cycle pulse that arms a new load.
- `s_byte`  in  8  stream byte.
- `s_vld`  in  1  stream byte valid.
- `s_last`  in  1  marks the final byte of the binary; qualified by `s_vld`.
- `s_rdy`  out  1  loader accepts a byte this cycle.
- `we`  out  1  write strobe to instruction memory, one cycle per window.
- `write_pointer_shift_minusone`  out  LOG_WIN  number of valid bytes in `wr_data`, minus 1.
- `wr_data`  out  WIN*8  packed bytes; lane k occupies [k*8+:8], lane 0 holds the earliest byte.
- `byte_cnt`  out  CNT_W  bytes accepted since `start`.
- `load_done`  out  1  level; the load completed cleanly.
- `hdr_err`  out  1  level; preamble mismatch, or `s_last` arrived within the first 8 bytes.
- `ovf_err`  out  1  level; the CAP-th byte was accepted without `s_last`.

## Operation
- FSM states: IDLE, HDR, BODY, DONE, ERR. Reset state is IDLE.
- `start` in IDLE, DONE or ERR:
  - clears `byte_cnt`, the pack register and all flags;
  - moves the FSM to HDR.
  - `start` is ignored in HDR and BODY.
- `s_rdy` = 1 only in HDR or BODY.
- A byte is accepted when `s_vld & s_rdy` is high at the clock edge. On acceptance:
  - the byte is written into lane `byte_cnt mod WIN` of the pack register;
  - `byte_cnt` increments.
- HDR state:
  - Each accepted byte with `byte_cnt` < 8 is compared against preamble byte `byte_cnt`.
  - Mismatch: go to ERR, set `hdr_err`, and discard the partial window (no `we`).
  - `s_last` on any of these 8 bytes: treated the same as a mismatch.
  - Acceptance of the 8th byte (`byte_cnt` 7 -> 8) with a match: go to BODY.
  - Preamble bytes are stored in memory like any other byte.
- Window emit: when an accepted byte fills lane WIN-1, or carries `s_last`, the outputs register on the same edge:
  - `wr_data` <= packed lanes including the incoming byte, with unused lanes zero;
  - `write_pointer_shift_minusone` <= (number of lanes filled) - 1;
  - `we` <= 1;
  - the pack register clears.
- `we` deasserts on the following edge unless another emit happens. `wr_data` holds its value between emits.
- `s_last` accepted in BODY: emit the window, go to DONE, set `load_done`.
- Capacity: if the accepted byte makes `byte_cnt` = CAP without `s_last`:
  - emit the window;
  - go to ERR and set `ovf_err`.
- `s_last` exactly on byte CAP goes to DONE; it is not an overflow.
- Arithmetic: `byte_cnt` never exceeds CAP. The lane index is the low LOG_WIN bits of `byte_cnt` (WIN is a power of two).
- Flags hold until the next `start` or reset. At most one of `load_done`, `hdr_err`, `ovf_err` is set at a time.

## Timing
- Reset (async, `rst_n` low):
  - all outputs 0: `s_rdy`, `we`, `write_pointer_shift_minusone`, `wr_data`, `byte_cnt`, `load_done`, `hdr_err`, `ovf_err`;
  - state IDLE, pack register 0.
  - Reset mid-load abandons the load; no `we` is issued afterwards.
- `start` at edge N: `s_rdy` = 1 from cycle N+1.
- Throughput is 1 byte per cycle with no stall. `s_rdy` never drops during a load because the emit register and the pack register are separate.
- `we` latency: high for exactly one cycle, in the cycle after the byte that completes the window is accepted.
- Consecutive windows at full rate give `we` high every WIN cycles.
- `load_done`, `hdr_err` and `ovf_err` rise in the same cycle as the corresponding final `we`, or in the cycle after the offending byte when no `we` is issued.
- `s_rdy` falls in that same cycle.
- `s_vld` high while `s_rdy` = 0: the byte is not consumed and there are no side effects.

## Test plan
- Minimal valid binary: `start`, then 8 preamble bytes plus 0x01 0x07 with `s_last` on 0x07 (10 bytes). Required:
  - `we` twice with shift 3, `wr_data` 0x6d736100 then 0x00000001;
  - a third `we` with shift 1 and `wr_data` 0x00000701;
  - `load_done` = 1, `byte_cnt` = 10.
- Bad magic: third byte 0x74 instead of 0x73 -> `hdr_err` = 1 one cycle later, `s_rdy` = 0, no `we` at any time, `byte_cnt` = 3.
- Short stream: `s_last` on the 5th preamble byte -> `hdr_err` = 1, no `we` after the first window, `load_done` = 0.
- Overflow with CAP = 16: 17 bytes offered with no `s_last` -> four `we` pulses with shift 3, then `ovf_err` = 1, `s_rdy` = 0, byte 17 not consumed, `byte_cnt` = 16.
- Exact fit with CAP = 16: `s_last` on byte 16 -> `load_done` = 1 and `ovf_err` = 0.
- Reset and restart: `rst_n` pulsed low mid-BODY -> all outputs 0 immediately. A subsequent `start` plus a valid 9-byte stream loads cleanly with shift 0 on the final `we`.
